// File: rtl/banana_tracker.sv
// Per-level banana collection mask, running count and timed bonus window.
// Optional BANANA_DEBOUNCE_EN requires each collide bit high for two cycles.
module banana_tracker #(
  parameter int NUM_BANANAS  = 5,
  parameter int CNT_W        = 3,
  parameter int BONUS_CYCLES = 60
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   level_restart,
  input  logic [NUM_BANANAS-1:0] collide,
  output logic [NUM_BANANAS-1:0] banana_mask,
  output logic [CNT_W-1:0]       count,
  output logic                   collect_pulse,
  output logic                   all_collected,
  output logic                   bonus_active
);

  localparam int BW =
    (BONUS_CYCLES > 1) ? $clog2(BONUS_CYCLES) : 1;

  localparam logic [NUM_BANANAS-1:0] ALL =
    {NUM_BANANAS{1'b1}};

  typedef enum logic [1:0] {
    PLAY,
    COMPLETE,
    DONE
  } state_t;

  state_t                 state;
  logic [NUM_BANANAS-1:0] collide_q;
  logic [NUM_BANANAS-1:0] nw;
  logic [NUM_BANANAS-1:0] nxt_mask;
  logic [CNT_W-1:0]       pc;
  logic [BW-1:0]          bonus_cnt;

`ifdef BANANA_DEBOUNCE_EN
  logic [NUM_BANANAS-1:0] collide_qq;

  // Event needs two consecutive high samples after a low one.
  always_comb begin
    nw = collide & collide_q & ~collide_qq & ~banana_mask;
  end
`else
  // Event on a single-cycle rising edge of an uncollected banana.
  always_comb begin
    nw = collide & ~collide_q & ~banana_mask;
  end
`endif

  // Number of bananas gained this cycle and the resulting mask.
  always_comb begin
    pc = '0;
    for (int i = 0; i < NUM_BANANAS; i++) begin
      pc = pc + CNT_W'(nw[i]);
    end
    nxt_mask = banana_mask | nw;
  end

  // Level state machine with registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset || level_restart) begin
      state         <= PLAY;
      collide_q     <= '0;
`ifdef BANANA_DEBOUNCE_EN
      collide_qq    <= '0;
`endif
      banana_mask   <= '0;
      count         <= '0;
      collect_pulse <= 1'b0;
      all_collected <= 1'b0;
      bonus_active  <= 1'b0;
      bonus_cnt     <= '0;
    end else begin
      collide_q     <= collide;
`ifdef BANANA_DEBOUNCE_EN
      collide_qq    <= collide_q;
`endif
      collect_pulse <= 1'b0;
      unique case (state)
        PLAY: begin
          if (|nw) begin
            banana_mask   <= nxt_mask;
            count         <= count + pc;
            collect_pulse <= 1'b1;
            if (nxt_mask == ALL) begin
              state         <= COMPLETE;
              all_collected <= 1'b1;
              bonus_active  <= 1'b1;
              bonus_cnt     <= BW'(BONUS_CYCLES - 1);
            end
          end
        end
        COMPLETE: begin
          if (bonus_cnt == '0) begin
            state        <= DONE;
            bonus_active <= 1'b0;
          end else begin
            bonus_cnt <= bonus_cnt - BW'(1);
          end
        end
        DONE: begin
          all_collected <= 1'b1;
          bonus_active  <= 1'b0;
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_banana_tracker.sv
// Directed bench for banana_tracker: vector table plus
// hand sequences for the bonus window and restart cases.
module tb_banana_tracker;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       level_restart = 1'b0;
  logic [4:0] collide = '0;
  logic [4:0] banana_mask;
  logic [2:0] count;
  logic       collect_pulse;
  logic       all_collected;
  logic       bonus_active;

  int checks = 0;
  int errors = 0;

  banana_tracker dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .level_restart (level_restart),
    .collide       (collide),
    .banana_mask   (banana_mask),
    .count         (count),
    .collect_pulse (collect_pulse),
    .all_collected (all_collected),
    .bonus_active  (bonus_active)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic [4:0] col;
    logic [4:0] mask;
    logic [2:0] cnt;
    logic       pulse;
    logic       all;
    logic       bonus;
  } vec_t;

  function automatic logic [10:0] pack(
    logic [4:0] m, logic [2:0] c,
    logic p, logic a, logic b);
    return {m, c, p, a, b};
  endfunction

  task automatic chk(string name,
                     logic [10:0] act,
                     logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  task automatic step(logic rst, logic [4:0] col);
    level_restart = rst;
    collide = col;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [10:0] outs();
    return pack(banana_mask, count, collect_pulse,
                all_collected, bonus_active);
  endfunction

  initial begin
    vec_t v[$];
    int n;

    @(posedge Clk);
    @(posedge Clk);
    #1;
    chk("reset", outs(), pack(5'b0, 3'd0, 0, 0, 0));
    Reset = 1'b0;

`ifndef BANANA_DEBOUNCE_EN
    // rst col mask cnt pulse all bonus
    v.push_back('{0, 5'b00100, 5'b00100, 1, 1, 0, 0});
    v.push_back('{0, 5'b00100, 5'b00100, 1, 0, 0, 0});
    v.push_back('{0, 5'b00100, 5'b00100, 1, 0, 0, 0});
    v.push_back('{0, 5'b00000, 5'b00100, 1, 0, 0, 0});
    v.push_back('{0, 5'b00100, 5'b00100, 1, 0, 0, 0});
    v.push_back('{1, 5'b00000, 5'b00000, 0, 0, 0, 0});
    v.push_back('{0, 5'b10011, 5'b10011, 3, 1, 0, 0});
    v.push_back('{0, 5'b10011, 5'b10011, 3, 0, 0, 0});
    v.push_back('{0, 5'b10111, 5'b10111, 4, 1, 0, 0});
    v.push_back('{1, 5'b00000, 5'b00000, 0, 0, 0, 0});
    v.push_back('{0, 5'b00001, 5'b00001, 1, 1, 0, 0});
    v.push_back('{0, 5'b00011, 5'b00011, 2, 1, 0, 0});
    v.push_back('{0, 5'b00111, 5'b00111, 3, 1, 0, 0});
    v.push_back('{0, 5'b01111, 5'b01111, 4, 1, 0, 0});
    v.push_back('{0, 5'b11111, 5'b11111, 5, 1, 1, 1});

    for (int i = 0; i < v.size(); i++) begin
      step(v[i].rst, v[i].col);
      chk($sformatf("vec%0d", i), outs(),
          pack(v[i].mask, v[i].cnt, v[i].pulse,
               v[i].all, v[i].bonus));
    end

    // Bonus window length, first sample already high.
    n = 1;
    for (int k = 0; k < 100 && bonus_active; k++) begin
      step(0, 5'b11111);
      if (bonus_active) n++;
    end
    checks++;
    if (n != 60) begin
      errors++;
      $display("FAIL bonus_len actual=%0d required=60", n);
    end
    chk("done", outs(), pack(5'b11111, 3'd5, 0, 1, 0));

    // Collisions ignored in DONE.
    for (int k = 0; k < 6; k++) begin
      step(0, (k % 2) ? 5'b11111 : 5'b00000);
      chk($sformatf("done_tgl%0d", k), outs(),
          pack(5'b11111, 3'd5, 0, 1, 0));
    end

    // Restart during the bonus window.
    step(1, 5'b00000);
    chk("rst2", outs(), pack(5'b0, 3'd0, 0, 0, 0));
    step(0, 5'b11111);
    chk("all_at_once", outs(), pack(5'b11111, 3'd5, 1, 1, 1));
    for (int k = 0; k < 19; k++) step(0, 5'b11111);
    chk("bonus20", outs(), pack(5'b11111, 3'd5, 0, 1, 1));
    step(1, 5'b00001);
    chk("abort", outs(), pack(5'b0, 3'd0, 0, 0, 0));
    step(0, 5'b00001);
    chk("post_rst", outs(), pack(5'b00001, 3'd1, 1, 0, 0));
    step(0, 5'b00001);
    chk("post_hold", outs(), pack(5'b00001, 3'd1, 0, 0, 0));

    // Reset wins over level_restart and collisions.
    Reset = 1'b1;
    step(1, 5'b11110);
    chk("rst_pri", outs(), pack(5'b0, 3'd0, 0, 0, 0));
    Reset = 1'b0;
`else
    step(0, 5'b01000);
    chk("glitch_a", outs(), pack(5'b0, 3'd0, 0, 0, 0));
    step(0, 5'b00000);
    chk("glitch_b", outs(), pack(5'b0, 3'd0, 0, 0, 0));
    step(0, 5'b00000);
    chk("glitch_c", outs(), pack(5'b0, 3'd0, 0, 0, 0));
    step(0, 5'b01000);
    chk("deb_1", outs(), pack(5'b0, 3'd0, 0, 0, 0));
    step(0, 5'b01000);
    chk("deb_2", outs(), pack(5'b01000, 3'd1, 1, 0, 0));
    step(0, 5'b01000);
    chk("deb_3", outs(), pack(5'b01000, 3'd1, 0, 0, 0));
    step(0, 5'b01001);
    chk("deb_4", outs(), pack(5'b01000, 3'd1, 0, 0, 0));
    step(0, 5'b01001);
    chk("deb_5", outs(), pack(5'b01001, 3'd2, 1, 0, 0));
    step(1, 5'b00000);
    chk("deb_rst", outs(), pack(5'b0, 3'd0, 0, 0, 0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
